// File: rtl/acc_stream_rx_pkg.sv
// Shared defaults and counter types for the accumulator stream receiver.
package acc_stream_rx_pkg;

  localparam int          DATA_W_DEF = 8;
  localparam int          DEPTH_DEF  = 8;
  localparam logic [7:0]  STEP_DEF   = 8'h02;

  localparam int RX_CNT_W  = 16;
  localparam int ERR_CNT_W = 8;

  typedef logic [RX_CNT_W-1:0]  rx_cnt_t;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  // Saturating increments, so both counters stick at all-ones.
  function automatic rx_cnt_t rx_cnt_inc(input rx_cnt_t v);
    return (v == '1) ? v : v + rx_cnt_t'(1);
  endfunction

  function automatic err_cnt_t err_cnt_inc(input err_cnt_t v);
    return (v == '1) ? v : v + err_cnt_t'(1);
  endfunction

endpackage

// File: rtl/acc_stream_rx_sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous active-low reset.
// The head word is presented combinationally; reads on empty are ignored
// and writes on full are accepted only when a read frees a slot that cycle.
module sync_fifo
  import acc_stream_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_wr;
  logic              do_rd;

  // The extra pointer bit tells full apart from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Head word is forced to zero while empty so the output is clean out of reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointers; indices wrap naturally because DEPTH is a power of two.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptying is done by the pointers, which keeps it a plain RAM.
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/acc_stream_rx.sv
// Receiving end of the accumulator test stream. Synchronises the asynchronous
// strobe and data, captures a word on each armed strobe rising edge, buffers
// it in a show-ahead FIFO and checks that consecutive words advance by STEP.
module acc_stream_rx
  import acc_stream_rx_pkg::*;
#(
  parameter int              DATA_W = DATA_W_DEF,
  parameter int              DEPTH  = DEPTH_DEF,
  parameter logic [DATA_W-1:0] STEP = DATA_W'(STEP_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_strobe,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 overflow,
  output logic [RX_CNT_W-1:0]  rx_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Synchroniser chains. fill_q marks which strobe stages hold real samples
  // rather than reset zeros, so arming only trusts a genuinely low s3.
  logic              s1_q, s2_q, s3_q;
  logic [DATA_W-1:0] d1_q, d2_q;
  logic [2:0]        fill_q;

  logic              armed_q, armed_d;
  logic              rise;
  logic              capture;

  logic              chk_armed_q, chk_armed_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] expected;
  rx_cnt_t           rx_cnt_q, rx_cnt_d;
  err_cnt_t          err_cnt_q, err_cnt_d;
  logic              ovf_q, ovf_d;

  logic              fifo_empty;
  logic              fifo_full;

  // Strobe and data synchronisers plus the fill marker.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      d1_q   <= '0;
      d2_q   <= '0;
      fill_q <= '0;
    end else begin
      s1_q   <= in_strobe;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      d1_q   <= in_data;
      d2_q   <= d1_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign capture = rise & armed_q;
  assign armed_d = armed_q | (fill_q[2] & ~s3_q);

  // Edge arming: a strobe already high at reset release never captures.
  always_ff @(posedge clk) begin
    if (!rst) armed_q <= 1'b0;
    else      armed_q <= armed_d;
  end

  assign expected = prev_q + STEP;

  // Checker, counters and overflow next-state.
  always_comb begin
    prev_d      = prev_q;
    chk_armed_d = chk_armed_q;
    rx_cnt_d    = rx_cnt_q;
    err_cnt_d   = err_cnt_q;
    ovf_d       = ovf_q;
    if (capture) begin
      rx_cnt_d    = rx_cnt_inc(rx_cnt_q);
      prev_d      = d2_q;
      chk_armed_d = 1'b1;
      if (chk_armed_q && (d2_q != expected)) err_cnt_d = err_cnt_inc(err_cnt_q);
      if (fifo_full && !rd_en) ovf_d = 1'b1;
    end
  end

  // Checker, counter and overflow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q      <= '0;
      chk_armed_q <= 1'b0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      chk_armed_q <= chk_armed_d;
      rx_cnt_q    <= rx_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (d2_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign rd_valid  = ~fifo_empty;
  assign full      = fifo_full;
  assign overflow  = ovf_q;
  assign rx_count  = rx_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_acc_stream_rx.sv
// Directed bench for acc_stream_rx: capture, wrap, step errors, overflow,
// full-boundary read/write, and reset/arming behaviour.
module tb_acc_stream_rx;
  import acc_stream_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_strobe = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        full;
  logic        overflow;
  logic [15:0] rx_count;
  logic [7:0]  err_count;

  int n_pass  = 0;
  int n_total = 0;

  acc_stream_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .overflow  (overflow),
    .rx_count  (rx_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reset with strobe low, then give the arming logic time to see s3 low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_strobe = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // One strobe transaction; optionally checks write latency or pulses rd_en
  // exactly in the cycle whose edge performs the FIFO write.
  task automatic send(input logic [7:0] d, input bit lat, input bit pulse_rd);
    @(negedge clk);
    in_data = d;
    repeat (2) @(negedge clk);
    in_strobe = 1'b1;
    @(negedge clk);                       // edge 1 done
    @(negedge clk);                       // edge 2 done
    if (lat) check("lat_edge2_rd_valid", 32'(rd_valid), 32'd0);
    if (pulse_rd) rd_en = 1'b1;
    @(negedge clk);                       // edge 3 done: write performed
    rd_en = 1'b0;
    if (lat) check("lat_edge3_rd_valid", 32'(rd_valid), 32'd1);
    repeat (3) @(negedge clk);
    in_strobe = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    @(negedge clk);
    check(tag, 32'(rd_data), 32'(d));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // Basic capture
    send(8'h02, 1'b1, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h06, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b0);
    send(8'h0A, 1'b0, 1'b0);
    check("basic_rx_count", 32'(rx_count), 32'd5);
    check("basic_err_count", 32'(err_count), 32'd0);
    check("basic_rd_valid", 32'(rd_valid), 32'd1);
    for (int i = 0; i < 5; i++) pop_expect("basic_pop", 8'(2 * (i + 1)));
    @(negedge clk);
    check("basic_drained", 32'(rd_valid), 32'd0);
    // Read while empty is ignored
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("empty_read_ignored", 32'(rd_valid), 32'd0);

    // Wrap-around is a legal step
    do_reset();
    send(8'hFC, 1'b0, 1'b0);
    send(8'hFE, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    check("wrap_rx_count", 32'(rx_count), 32'd4);
    check("wrap_err_count", 32'(err_count), 32'd0);

    // Step errors: 04->07 expected 06, 07->0A expected 09
    do_reset();
    send(8'h02, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    send(8'h0A, 1'b0, 1'b0);
    check("step_err_count", 32'(err_count), 32'd2);
    check("step_rx_count", 32'(rx_count), 32'd4);

    // Overflow: 9 words into an 8-deep FIFO with no reads
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(8'h10 + 2 * i), 1'b0, 1'b0);
    check("ovf_full_after8", 32'(full), 32'd1);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    send(8'h20, 1'b0, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_rx_count", 32'(rx_count), 32'd9);
    check("ovf_err_count", 32'(err_count), 32'd0);
    for (int i = 0; i < 8; i++) pop_expect("ovf_pop", 8'(8'h10 + 2 * i));
    @(negedge clk);
    check("ovf_drained", 32'(rd_valid), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);

    // Full boundary: read in the exact write cycle
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(8'h02 + 2 * i), 1'b0, 1'b0);
    check("fb_full", 32'(full), 32'd1);
    send(8'h12, 1'b0, 1'b1);
    check("fb_no_overflow", 32'(overflow), 32'd0);
    check("fb_still_full", 32'(full), 32'd1);
    check("fb_rx_count", 32'(rx_count), 32'd9);
    for (int i = 0; i < 8; i++) pop_expect("fb_pop", 8'(8'h04 + 2 * i));

    // Strobe held high across reset release: no capture
    @(negedge clk);
    rst = 1'b0;
    in_data = 8'h55;
    in_strobe = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_rx_count", 32'(rx_count), 32'd0);
    check("hold_rd_valid", 32'(rd_valid), 32'd0);
    in_strobe = 1'b0;
    repeat (6) @(negedge clk);
    send(8'h30, 1'b0, 1'b0);
    check("hold_then_rx", 32'(rx_count), 32'd1);
    check("hold_then_data", 32'(rd_data), 32'h30);

    // Reset one cycle after a strobe edge discards it
    @(negedge clk);
    in_data = 8'h50;
    repeat (2) @(negedge clk);
    in_strobe = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    in_strobe = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_rx_count", 32'(rx_count), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);

    // First word after reset is not checked (0x99 != 0x30 + 2)
    send(8'h99, 1'b0, 1'b0);
    check("rearm_rx_count", 32'(rx_count), 32'd1);
    check("rearm_err_count", 32'(err_count), 32'd0);
    check("rearm_rd_data", 32'(rd_data), 32'h99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
